// File: rtl/che_cmf_fch_pkg.sv
// Shared constants for the che_* contrast-mapping blocks: default geometry,
// the LOG2 helper and the fetch FSM state type.
package che_cmf_fch_pkg;

  localparam int CHE_DAT_PIX_WD = 8;
  localparam int CHE_TILE_SIZ   = 64;
  localparam int CHE_FRA_WD     = 256;
  localparam int CHE_FRA_HT     = 256;

  // Ceiling log2, usable in constant expressions.
  function automatic int che_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACTV = 1'b1
  } cmf_st_e;

  localparam int LANE_NUM = 4;

endpackage

// File: rtl/che_cmf_axs.sv
// One axis of the tile-fetch decision: half-tile offset, neighbouring tile
// pair (or single tile at the frame edges) and interpolation weight.
module che_cmf_axs
  import che_cmf_fch_pkg::*;
#(
  parameter int LEN      = CHE_FRA_WD,
  parameter int TILE_SIZ = CHE_TILE_SIZ,
  parameter int CW       = che_log2(LEN),
  parameter int PW       = che_log2(TILE_SIZ),
  parameter int TW       = CW - PW
) (
  input  logic [CW-1:0] crd_i,
  output logic [TW-1:0] t0_o,
  output logic [TW-1:0] t1_o,
  output logic [PW-1:0] pos_o,
  output logic          pair_o
);

  logic [CW:0]   off;
  logic [TW-1:0] tile;
  logic          neg;

  // Two's-complement offset; the extra top bit is the sign.
  assign off  = {1'b0, crd_i} - (CW + 1)'(TILE_SIZ / 2);
  assign neg  = off[CW];
  assign tile = off[CW-1:PW];

  assign pair_o = !neg && (tile != TW'(LEN / TILE_SIZ - 1));
  assign t0_o   = neg ? '0 : tile;
  assign t1_o   = pair_o ? tile + TW'(1) : t0_o;
  assign pos_o  = pair_o ? off[PW-1:0] : '0;

endmodule

// File: rtl/che_cmf_fch.sv
// Contrast-mapping LUT fetch: tracks the raster position, issues up to four
// LUT reads per pixel (ul/ur/bl/br tiles) and forwards the data with weights.
module che_cmf_fch
  import che_cmf_fch_pkg::*;
#(
  parameter int DAT_PIX_WD = CHE_DAT_PIX_WD,
  parameter int TILE_SIZ   = CHE_TILE_SIZ,
  parameter int FRA_WD     = CHE_FRA_WD,
  parameter int FRA_HT     = CHE_FRA_HT,
  parameter int TILE_NUM_X = FRA_WD / TILE_SIZ,
  parameter int TILE_NUM_Y = FRA_HT / TILE_SIZ,
  parameter int ADR_WD     = che_log2(TILE_NUM_X * TILE_NUM_Y) + DAT_PIX_WD
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        vld_i,
  input  logic                        sof_i,
  input  logic [DAT_PIX_WD-1:0]       dat_i,
  output logic                        ul_rd_en_o,
  output logic                        ur_rd_en_o,
  output logic                        bl_rd_en_o,
  output logic                        br_rd_en_o,
  output logic [ADR_WD-1:0]           ul_rd_adr_o,
  output logic [ADR_WD-1:0]           ur_rd_adr_o,
  output logic [ADR_WD-1:0]           bl_rd_adr_o,
  output logic [ADR_WD-1:0]           br_rd_adr_o,
  input  logic [DAT_PIX_WD-1:0]       ul_rd_dat_i,
  input  logic [DAT_PIX_WD-1:0]       ur_rd_dat_i,
  input  logic [DAT_PIX_WD-1:0]       bl_rd_dat_i,
  input  logic [DAT_PIX_WD-1:0]       br_rd_dat_i,
  output logic                        ul_vld_o,
  output logic                        ur_vld_o,
  output logic                        bl_vld_o,
  output logic                        br_vld_o,
  output logic [DAT_PIX_WD-1:0]       ul_dat_o,
  output logic [DAT_PIX_WD-1:0]       ur_dat_o,
  output logic [DAT_PIX_WD-1:0]       bl_dat_o,
  output logic [DAT_PIX_WD-1:0]       br_dat_o,
  output logic [che_log2(TILE_SIZ)-1:0] pos_x_o,
  output logic [che_log2(TILE_SIZ)-1:0] pos_y_o,
  output logic                        done_o
);

  localparam int XW  = che_log2(FRA_WD);
  localparam int YW  = che_log2(FRA_HT);
  localparam int PW  = che_log2(TILE_SIZ);
  localparam int TXW = XW - PW;
  localparam int TYW = YW - PW;
  localparam int TIW = che_log2(TILE_NUM_X * TILE_NUM_Y);

  cmf_st_e              st_q, st_d;
  logic [XW-1:0]        x_q, x_d, cur_x;
  logic [YW-1:0]        y_q, y_d, cur_y;
  logic                 acc, last;

  logic [TXW-1:0]       tx0, tx1;
  logic [TYW-1:0]       ty0, ty1;
  logic [PW-1:0]        px, py;
  logic                 pair_x, pair_y;

  logic [LANE_NUM-1:0]              en_d;
  logic [LANE_NUM-1:0][ADR_WD-1:0]  adr_d;

  logic [LANE_NUM-1:0]              rd_en_q;
  logic [LANE_NUM-1:0][ADR_WD-1:0]  rd_adr_q;
  logic [PW-1:0]                    px_s1_q, py_s1_q;
  logic                             last_s1_q;
  logic [LANE_NUM-1:0]              vld_q;
  logic [PW-1:0]                    pos_x_q, pos_y_q;
  logic                             done_q;

  // A sof pixel is always (0,0), whether it opens or restarts a frame.
  always_comb begin
    acc   = vld_i && (sof_i || st_q == ST_ACTV);
    cur_x = sof_i ? '0 : x_q;
    cur_y = sof_i ? '0 : y_q;
    last  = (cur_x == XW'(FRA_WD - 1)) && (cur_y == YW'(FRA_HT - 1));
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    if (acc) begin
      if (last) begin
        st_d = ST_IDLE;
        x_d  = '0;
        y_d  = '0;
      end else begin
        st_d = ST_ACTV;
        if (cur_x == XW'(FRA_WD - 1)) begin
          x_d = '0;
          y_d = cur_y + YW'(1);
        end else begin
          x_d = cur_x + XW'(1);
          y_d = cur_y;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q <= ST_IDLE;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      st_q <= st_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  che_cmf_axs #(.LEN(FRA_WD), .TILE_SIZ(TILE_SIZ)) u_axs_x (
    .crd_i (cur_x),
    .t0_o  (tx0),
    .t1_o  (tx1),
    .pos_o (px),
    .pair_o(pair_x)
  );

  che_cmf_axs #(.LEN(FRA_HT), .TILE_SIZ(TILE_SIZ)) u_axs_y (
    .crd_i (cur_y),
    .t0_o  (ty0),
    .t1_o  (ty1),
    .pos_o (py),
    .pair_o(pair_y)
  );

  // Lane order: 0=ul, 1=ur, 2=bl, 3=br; ul is present for every pixel.
  assign en_d = {pair_x & pair_y, pair_y, pair_x, 1'b1};

  generate
    for (genvar gi = 0; gi < LANE_NUM; gi++) begin : g_lane
      localparam bit RIGHT = (gi % 2) == 1;
      localparam bit BOT   = gi >= 2;
      logic [TXW-1:0] col;
      logic [TYW-1:0] row;
      logic [TIW-1:0] tidx;
      assign col        = RIGHT ? tx1 : tx0;
      assign row        = BOT ? ty1 : ty0;
      assign tidx       = TIW'(row) * TIW'(TILE_NUM_X) + TIW'(col);
      assign adr_d[gi]  = {tidx, dat_i};
    end
  endgenerate

  // Stage 1 issues the LUT reads, stage 2 lines up with the returned data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_en_q   <= '0;
      rd_adr_q  <= '0;
      px_s1_q   <= '0;
      py_s1_q   <= '0;
      last_s1_q <= 1'b0;
      vld_q     <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q   <= acc ? en_d : '0;
      last_s1_q <= acc && last;
      if (acc) begin
        rd_adr_q <= adr_d;
        px_s1_q  <= px;
        py_s1_q  <= py;
      end
      vld_q  <= rd_en_q;
      done_q <= last_s1_q;
      if (rd_en_q[0]) begin
        pos_x_q <= px_s1_q;
        pos_y_q <= py_s1_q;
      end
    end
  end

  assign ul_rd_en_o  = rd_en_q[0];
  assign ur_rd_en_o  = rd_en_q[1];
  assign bl_rd_en_o  = rd_en_q[2];
  assign br_rd_en_o  = rd_en_q[3];
  assign ul_rd_adr_o = rd_adr_q[0];
  assign ur_rd_adr_o = rd_adr_q[1];
  assign bl_rd_adr_o = rd_adr_q[2];
  assign br_rd_adr_o = rd_adr_q[3];
  assign ul_vld_o    = vld_q[0];
  assign ur_vld_o    = vld_q[1];
  assign bl_vld_o    = vld_q[2];
  assign br_vld_o    = vld_q[3];
  assign ul_dat_o    = ul_rd_dat_i;
  assign ur_dat_o    = ur_rd_dat_i;
  assign bl_dat_o    = bl_rd_dat_i;
  assign br_dat_o    = br_rd_dat_i;
  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign done_o      = done_q;

endmodule

// File: doc/che_cmf_fch.md
CHE_CMF_FCH -- requirements
Module: che_cmf_fch

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- DAT_PIX_WD, 8, pixel and mapping-LUT data width.
- TILE_SIZ, 64, tile edge in pixels (power of two).
- FRA_WD, 256, frame width in pixels.
- FRA_HT, 256, frame height in pixels.
- Derived: TILE_NUM_X = FRA_WD/TILE_SIZ (4), TILE_NUM_Y = FRA_HT/TILE_SIZ (4).
- Derived: ADR_WD = LOG2(TILE_NUM_X*TILE_NUM_Y) + DAT_PIX_WD (12).

REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock.
- rstn, in, 1, reset, asynchronous, active-low.
- vld_i, in, 1, input pixel valid; no backpressure.
- sof_i, in, 1, start of frame, qualified by vld_i.
- dat_i, in, DAT_PIX_WD, raster-order pixel.
- {ul,ur,bl,br}_rd_en_o, out, 1 each, LUT read enable per lane.
- {ul,ur,bl,br}_rd_adr_o, out, ADR_WD each, address = {tile_idx, pixel}.
- {ul,ur,bl,br}_rd_dat_i, in, DAT_PIX_WD each, LUT data, 1-cycle synchronous read latency.
- {ul,ur,bl,br}_vld_o, out, 1 each, lane valid toward the interpolator.
- {ul,ur,bl,br}_dat_o, out, DAT_PIX_WD each, lane data (= rd_dat_i).
- pos_x_o, out, LOG2(TILE_SIZ), horizontal weight.
- pos_y_o, out, LOG2(TILE_SIZ), vertical weight.
- done_o, out, 1, one-cycle pulse aligned with the last pixel of a frame.

Function
REQ-003 FSM SHALL have two states: IDLE and ACTV.
- IDLE->ACTV on vld_i&&sof_i.
- ACTV->IDLE on acceptance of pixel (FRA_WD-1, FRA_HT-1).
- In IDLE, vld_i without sof_i SHALL be ignored: no reads, no outputs.

REQ-004 Pixel counters x,y SHALL address the accepted pixel.
- sof_i pixel is (0,0).
- x increments per accepted pixel; it wraps from FRA_WD-1 to 0 and increments y.
- sof_i while in ACTV SHALL restart the frame at (0,0) without asserting done_o.

REQ-005 Per axis, the offset SHALL be xs = x - TILE_SIZ/2 (signed); define tx = xs>>LOG2(TILE_SIZ) and px = xs[LOG2-1:0]. Lane pairing:
- xs<0: single column, tile 0, left lanes only.
- tx == TILE_NUM_X-1: single column, tile tx, left lanes only.
- Otherwise: pair (tx, tx+1), pos_x = px.
- Same rules for y with ty/py/pos_y: a single row SHALL use the upper lanes only.

REQ-006 A single column SHALL drive ul/bl only (ur/br rd_en and vld = 0), and a single row SHALL drive ul/ur only. Single-axis pos SHALL be forced to 0.

REQ-007 tile_idx SHALL be row*TILE_NUM_X + col; the lane address SHALL be {tile_idx, dat_i}.

REQ-008 Latency:
- Pixel accepted at cycle N.
- rd_en/rd_adr registered at N+1.
- vld_o/dat_o/pos_x_o/pos_y_o/done_o valid at N+2.
- Full throughput, one pixel per cycle.

REQ-009 A lane's vld_o SHALL equal its rd_en delayed by one cycle; dat_o SHALL be the unregistered rd_dat_i.

REQ-010 While no pixel is in the pipeline, all rd_en and vld outputs SHALL be 0; addresses and pos outputs hold their last value.

REQ-011 The same lane-presence rules as REQ-006 SHALL apply in the corner regions (only ul active).

Reset
REQ-012 On rstn low, the block SHALL:
- enter IDLE;
- clear x, y and all pipeline registers;
- drive every rd_en, vld, pos, address and done_o output to 0.

REQ-013 Reset asserted mid-frame SHALL discard in-flight pixels; the first output after reset SHALL require a new sof_i.

Structure
REQ-014 DAT_PIX_WD, TILE_SIZ, FRA_WD, FRA_HT and the LOG2 macro SHALL come from the shared include file used by the che_* blocks.

REQ-015 One sub-module SHALL exist, che_cmf_axs (instanced for x and y): offset, tile index, pos and single/pair decision for one axis, purely combinational.

Verification
REQ-016 Pixel (0,0), sof_i=1, dat_i=0x10 -> at N+1, only ul_rd_en=1 with adr=0x010; at N+2, only ul_vld_o=1, pos_x_o=0, pos_y_o=0.

REQ-017 Pixel (100,40), dat_i=0x80 -> all four lanes valid:
- ul adr 0x180, ur adr 0x280, bl adr 0x580, br adr 0x680;
- pos_x_o=4, pos_y_o=8.

REQ-018 Pixel (255,255) -> only ul valid, adr {15,dat_i}, pos 0; done_o pulses at N+2; FSM returns to IDLE.

REQ-019 Pixel (40,10) -> ul (tile 0) and ur (tile 1) valid, bl/br off; pos_x_o=8, pos_y_o=0.

REQ-020 Mixed-condition checks:
- vld_i without sof_i in IDLE -> no rd_en for 10 cycles.
- sof_i at x=50 mid-frame -> next pixel counted as (1,0), no done_o.
- rstn pulse mid-frame -> outputs 0 at N+1, then silence until the next sof_i.
